// File: rtl/mem_hs.sv
// ============================================================================
// mem_hs -- byte-addressed data memory with a valid/ready handshake
//
// Sits between the datapath load/store stage and the byte storage array.
// Words are big-endian: byte k of a word (k = 0 is the MSB) lives at
// (req_addr + k) mod 2**ADDR_W, so an access at the top address wraps to 0.
// After reset, a hardware sweep writes every byte once before any request
// is accepted.  One transaction is outstanding at a time.
//
// Parameters
//   ADDR_W        byte-address width; depth = 2**ADDR_W bytes
//   BYTES         bytes per word (power of two, >= 1); DW = 8*BYTES
//   STRICT_ALIGN  1: addr % BYTES != 0 is rejected with rsp_err
//                 0: any address is allowed, byte addresses wrap
//
// Optional feature (compile-time macro MEM_PRELOAD_EN)
//   defined   : the sweep writes 2B CD 00 00 12 34 DE AD BE EF to bytes
//               0x00-0x09, all other bytes 0x00
//   undefined : every byte is swept to 0x00
//   Sweep length and timing are identical in both builds.
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   reset      in   synchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted when req_valid && req_ready
//   req_we     in   write the enabled bytes
//   req_re     in   read a word
//   req_addr   in   byte address of the word MSB
//   req_wdata  in   write data, [DW-1:DW-8] goes to req_addr
//   req_be     in   byte enables, bit BYTES-1 selects the MSB byte
//   rsp_valid  out  response present
//   rsp_ready  in   response consumed when rsp_valid && rsp_ready
//   rsp_rdata  out  read data (big-endian), held after the handshake
//   rsp_err    out  misaligned-access error
//   init_done  out  high once the initialisation sweep has completed
// ============================================================================
module mem_hs #(
    parameter int ADDR_W       = 8,
    parameter int BYTES        = 2,
    parameter bit STRICT_ALIGN = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic                 req_re,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [8*BYTES-1:0]   req_wdata,
    input  logic [BYTES-1:0]     req_be,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [8*BYTES-1:0]   rsp_rdata,
    output logic                 rsp_err,
    output logic                 init_done
);

    localparam int DW     = 8 * BYTES;
    localparam int LB     = $clog2(BYTES);          // 0 when BYTES == 1
    localparam int ROW_W  = ADDR_W - LB;
    localparam int ROWS   = 2 ** ROW_W;

    // Low address bits select the bank; they are also the misalignment bits.
    localparam logic [ADDR_W-1:0] BANK_MASK = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    // Sweep contents for the low addresses; all zero unless preloading.
    localparam int PRELOAD_LEN = 10;
`ifdef MEM_PRELOAD_EN
    localparam logic [7:0] PRELOAD [PRELOAD_LEN] =
        '{8'h2B, 8'hCD, 8'h00, 8'h00, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`else
    localparam logic [7:0] PRELOAD [PRELOAD_LEN] =
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt;

    // Request decode
    logic                access;       // accepted read and/or write
    logic                misaligned;
    logic [ADDR_W-1:0]   byte_addr [BYTES];
    logic [BYTES-1:0]    lane_we;      // indexed by word lane k (k = 0 is MSB)
    logic [DW-1:0]       rd_word;

    // Storage is split into BYTES banks by the low address bits. Any word
    // access, aligned or not, touches every bank exactly once, so each bank
    // needs only one write port.
    logic [BYTES-1:0]             bank_we;
    logic [BYTES-1:0][ROW_W-1:0]  bank_row;
    logic [BYTES-1:0][7:0]        bank_wdata;
    logic [7:0]                   bank_rdata [BYTES];

    function automatic logic [7:0] init_byte(input logic [ADDR_W-1:0] a);
        logic [7:0] b;
        b = 8'h00;
        for (int unsigned i = 0; i < PRELOAD_LEN; i++) begin
            if (32'(a) == i) begin
                b = PRELOAD[i];
            end
        end
        return b;
    endfunction

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case leaves it unassigned (which would infer a latch).
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            INIT: begin
                if (init_cnt == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                req_ready = 1'b1;
                // A request with neither re nor we is accepted and dropped.
                if (req_valid && (req_re || req_we)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign access    = (state_q == IDLE) && req_valid && (req_re || req_we);
    assign init_done = (state_q != INIT);

    // ------------------------------------------------------------------
    // Address generation, alignment check, lane write enables
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < BYTES; k++) begin
            byte_addr[k] = req_addr + ADDR_W'(k);
        end
        misaligned = STRICT_ALIGN && ((req_addr & BANK_MASK) != '0);
        lane_we    = '0;
        if (access && req_we && !misaligned) begin
            for (int k = 0; k < BYTES; k++) begin
                lane_we[k] = req_be[BYTES-1-k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank port steering: the sweep owns the ports in INIT, the request
    // address owns them otherwise (reads need the row even without a write).
    // ------------------------------------------------------------------
    always_comb begin
        bank_we    = '0;
        bank_row   = '0;
        bank_wdata = '0;
        if (state_q == INIT) begin
            for (int b = 0; b < BYTES; b++) begin
                if (int'(init_cnt & BANK_MASK) == b) begin
                    bank_we[b]    = 1'b1;
                    bank_row[b]   = ROW_W'(init_cnt >> LB);
                    bank_wdata[b] = init_byte(init_cnt);
                end
            end
        end else begin
            for (int b = 0; b < BYTES; b++) begin
                for (int k = 0; k < BYTES; k++) begin
                    if (int'(byte_addr[k] & BANK_MASK) == b) begin
                        bank_we[b]    = lane_we[k];
                        bank_row[b]   = ROW_W'(byte_addr[k] >> LB);
                        bank_wdata[b] = req_wdata[DW-1-8*k -: 8];
                    end
                end
            end
        end
    end

    // Read word assembled from the pre-write bank contents. A rejected or
    // write-only access returns zero.
    always_comb begin
        rd_word = '0;
        if (req_re && !misaligned) begin
            for (int k = 0; k < BYTES; k++) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (int'(byte_addr[k] & BANK_MASK) == b) begin
                        rd_word[DW-1-8*k -: 8] = bank_rdata[b];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage banks
    // ------------------------------------------------------------------
    for (genvar g = 0; g < BYTES; g++) begin : g_bank
        logic [7:0] mem [ROWS];

        // NOTE: the array has no reset branch; its contents are defined by
        // the INIT sweep, and a reset-driven clear of every entry would
        // prevent mapping to RAM. Writes are suppressed while reset is low
        // so an in-flight store is dropped.
        always_ff @(posedge clk) begin
            if (reset && bank_we[g]) begin
                mem[bank_row[g]] <= bank_wdata[g];
            end
        end

        assign bank_rdata[g] = mem[bank_row[g]];
    end

    // ------------------------------------------------------------------
    // State, sweep counter, response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state_q   <= INIT;
            init_cnt  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                init_cnt <= init_cnt + ADDR_W'(1);
            end
            if (access) begin
                rsp_rdata <= rd_word;
                rsp_err   <= misaligned;
            end else if (state_q == RESP && rsp_ready) begin
                // rsp_rdata intentionally keeps its value after the handshake.
                rsp_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_hs.sv
// ============================================================================
// tb_mem_hs -- self-checking bench for mem_hs (ADDR_W=8, BYTES=2)
//
// Instance 0 uses STRICT_ALIGN=0, instance 1 uses STRICT_ALIGN=1.
// Inputs are driven and outputs sampled on the falling clock edge.
// ============================================================================
module tb_mem_hs;

`ifdef MEM_PRELOAD_EN
    localparam logic [15:0] EXP_RD06 = 16'hDEAD;
    localparam logic [15:0] EXP_RD00 = 16'h2BCD;
    localparam logic [7:0]  EXP_B01  = 8'hCD;
`else
    localparam logic [15:0] EXP_RD06 = 16'h0000;
    localparam logic [15:0] EXP_RD00 = 16'h0000;
    localparam logic [7:0]  EXP_B01  = 8'h00;
`endif

    logic        clk;
    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic        req_re    [2];
    logic [7:0]  req_addr  [2];
    logic [15:0] req_wdata [2];
    logic [1:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        init_done [2];

    int n_cmp  = 0;
    int n_fail = 0;

    mem_hs #(.ADDR_W(8), .BYTES(2), .STRICT_ALIGN(1'b0)) u_lax (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_re(req_re[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .init_done(init_done[0])
    );

    mem_hs #(.ADDR_W(8), .BYTES(2), .STRICT_ALIGN(1'b1)) u_strict (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_re(req_re[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .init_done(init_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input string name, input logic we, input logic re,
                                    input logic [7:0] addr, input logic [15:0] wdata,
                                    input logic [1:0] be, input logic [15:0] exp_rdata,
                                    input logic exp_err);
        vec_t v;
        v.name = name; v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
        v.be = be; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge after the
    // response handshake with the DUT back in IDLE.
    task automatic run_txn(input int d, input logic we, input logic re,
                           input logic [7:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be, input logic [15:0] exp_rdata,
                           input logic exp_err, input string name);
        int n;
        req_valid[d] = 1'b1; req_we[d] = we; req_re[d] = re;
        req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
        rsp_ready[d] = 1'b1;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, " req_ready"}, req_ready[d], 1'b1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        check({name, " rsp_valid"}, rsp_valid[d], 1'b1);
        check({name, " rsp_rdata"}, rsp_rdata[d], exp_rdata);
        check({name, " rsp_err"}, rsp_err[d], exp_err);
        check({name, " busy"}, req_ready[d], 1'b0);
        @(negedge clk);
        check({name, " done"}, rsp_valid[d], 1'b0);
        check({name, " rdata held"}, rsp_rdata[d], exp_rdata);
        check({name, " err cleared"}, rsp_err[d], 1'b0);
    endtask

    // Called at the falling edge where reset is released.
    task automatic wait_init(input int d, input string name);
        int  n;
        logic ready_early;
        n = 0;
        ready_early = 1'b0;
        while (init_done[d] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (init_done[d] !== 1'b1 && req_ready[d] !== 1'b0) ready_early = 1'b1;
        end
        check({name, " sweep cycles"}, n, 256);
        check({name, " req_ready low in INIT"}, ready_early, 1'b0);
        check({name, " req_ready after INIT"}, req_ready[d], 1'b1);
    endtask

    task automatic check_reset_state(input int d, input string name);
        check({name, " req_ready"}, req_ready[d], 1'b0);
        check({name, " rsp_valid"}, rsp_valid[d], 1'b0);
        check({name, " rsp_rdata"}, rsp_rdata[d], 16'h0000);
        check({name, " rsp_err"}, rsp_err[d], 1'b0);
        check({name, " init_done"}, init_done[d], 1'b0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_re[d] = 1'b0;
            req_addr[d] = 8'h00; req_wdata[d] = 16'h0000; req_be[d] = 2'b00;
            rsp_ready[d] = 1'b0;
        end

        // Vector table for the STRICT_ALIGN=0 instance, applied in order.
        add_vec("rd06",        1'b0, 1'b1, 8'h06, 16'h0000, 2'b00, EXP_RD06, 1'b0);
        add_vec("rd00",        1'b0, 1'b1, 8'h00, 16'h0000, 2'b00, EXP_RD00, 1'b0);
        add_vec("wr20_hi",     1'b1, 1'b0, 8'h20, 16'hA5C3, 2'b10, 16'h0000, 1'b0);
        add_vec("rd20_a",      1'b0, 1'b1, 8'h20, 16'h0000, 2'b00, 16'hA500, 1'b0);
        add_vec("wr20_lo",     1'b1, 1'b0, 8'h20, 16'h1122, 2'b01, 16'h0000, 1'b0);
        add_vec("rd20_b",      1'b0, 1'b1, 8'h20, 16'h0000, 2'b00, 16'hA522, 1'b0);
        add_vec("wr20_no_be",  1'b1, 1'b0, 8'h20, 16'hFFFF, 2'b00, 16'h0000, 1'b0);
        add_vec("rd20_c",      1'b0, 1'b1, 8'h20, 16'h0000, 2'b00, 16'hA522, 1'b0);
        add_vec("wrFF",        1'b1, 1'b0, 8'hFF, 16'h7788, 2'b11, 16'h0000, 1'b0);
        add_vec("rdFF",        1'b0, 1'b1, 8'hFF, 16'h0000, 2'b00, 16'h7788, 1'b0);
        add_vec("rd00_wrap",   1'b0, 1'b1, 8'h00, 16'h0000, 2'b00, {8'h88, EXP_B01}, 1'b0);
        add_vec("wr40",        1'b1, 1'b0, 8'h40, 16'h1234, 2'b11, 16'h0000, 1'b0);
        add_vec("rw40",        1'b1, 1'b1, 8'h40, 16'hBEEF, 2'b11, 16'h1234, 1'b0);
        add_vec("rd40",        1'b0, 1'b1, 8'h40, 16'h0000, 2'b00, 16'hBEEF, 1'b0);
        add_vec("rd41_unalgn", 1'b0, 1'b1, 8'h41, 16'h0000, 2'b00, 16'hEF00, 1'b0);

        // One reset edge, then the sweep on both instances.
        @(negedge clk);
        check_reset_state(0, "reset lax");
        check_reset_state(1, "reset strict");
        reset[0] = 1'b1;
        reset[1] = 1'b1;
        wait_init(0, "init lax");
        check("init strict done", init_done[1], 1'b1);

        foreach (vecs[i]) begin
            run_txn(0, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata,
                    vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].name);
        end

        // No-op request: accepted, no response, previous rdata untouched.
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_re[0] = 1'b0;
        req_addr[0] = 8'h20; req_be[0] = 2'b11;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("noop rsp_valid", rsp_valid[0], 1'b0);
        check("noop stays idle", req_ready[0], 1'b1);
        check("noop rdata kept", rsp_rdata[0], 16'hEF00);
        @(negedge clk);

        // STRICT_ALIGN=1: aligned read, then misaligned write held in RESP.
        run_txn(1, 1'b0, 1'b1, 8'h06, 16'h0000, 2'b00, EXP_RD06, 1'b0, "s_rd06");

        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_re[1] = 1'b0;
        req_addr[1] = 8'h41; req_wdata[1] = 16'h1234; req_be[1] = 2'b11;
        rsp_ready[1] = 1'b0;
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("s_wr41 rsp_valid", rsp_valid[1], 1'b1);
        check("s_wr41 rsp_err", rsp_err[1], 1'b1);
        check("s_wr41 rsp_rdata", rsp_rdata[1], 16'h0000);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("s_hold%0d rsp_valid", c), rsp_valid[1], 1'b1);
            check($sformatf("s_hold%0d req_ready", c), req_ready[1], 1'b0);
            check($sformatf("s_hold%0d rsp_err", c), rsp_err[1], 1'b1);
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("s_wr41 released", rsp_valid[1], 1'b0);
        check("s_wr41 err cleared", rsp_err[1], 1'b0);

        run_txn(1, 1'b0, 1'b1, 8'h40, 16'h0000, 2'b00, 16'h0000, 1'b0, "s_rd40_unchanged");
        run_txn(1, 1'b0, 1'b1, 8'h42, 16'h0000, 2'b00, 16'h0000, 1'b0, "s_rd42_unchanged");
        run_txn(1, 1'b0, 1'b1, 8'h41, 16'h0000, 2'b00, 16'h0000, 1'b1, "s_rd41_err");
        run_txn(1, 1'b1, 1'b0, 8'h42, 16'hABCD, 2'b11, 16'h0000, 1'b0, "s_wr42");
        run_txn(1, 1'b0, 1'b1, 8'h42, 16'h0000, 2'b00, 16'hABCD, 1'b0, "s_rd42");

        // Reset while a response is pending: response dropped, sweep restarts.
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_re[1] = 1'b1;
        req_addr[1] = 8'h42; rsp_ready[1] = 1'b0;
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("s_resp_pending rsp_valid", rsp_valid[1], 1'b1);
        check("s_resp_pending rsp_rdata", rsp_rdata[1], 16'hABCD);
        reset[1] = 1'b0;
        @(negedge clk);
        check_reset_state(1, "reset in RESP");
        reset[1] = 1'b1;
        rsp_ready[1] = 1'b1;
        wait_init(1, "reinit strict");
        run_txn(1, 1'b0, 1'b1, 8'h42, 16'h0000, 2'b00, 16'h0000, 1'b0, "s_rd42_swept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_hs.md
Name: mem_hs

Overview:
- Parametrised successor of the byte-addressed data memory used by the datapath.
- Big-endian word access with per-byte write enables, a valid/ready request/response handshake, and a misaligned-access error path.
- After reset, a hardware sweep initialises the memory contents before any request is accepted.
- Sits between the datapath load/store stage and the byte storage array; one transaction is outstanding at a time.

Parameters:
- ADDR_W, 8, byte-address width; depth = 2**ADDR_W bytes.
- BYTES, 2, bytes per word; word width DW = 8*BYTES. Must be a power of two, ≥1.
- STRICT_ALIGN, 0:
  - 1: addresses with addr % BYTES != 0 are rejected with an error.
  - 0: any address is allowed, and byte addresses wrap.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a clk edge.
- req_we  in  1  write the selected bytes.
- req_re  in  1  read a word.
- req_addr  in  ADDR_W  byte address of the word MSB.
- req_wdata  in  DW  write data; bits [DW-1:DW-8] go to req_addr.
- req_be  in  BYTES  byte enables; bit BYTES-1 selects the MSB byte.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DW  read data (big-endian).
- rsp_err  out  1  misaligned-access error.
- init_done  out  1  high once the initialisation sweep completes.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to INIT and the sweep counter to 0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - Reset mid-transaction drops any pending response; writes not yet committed are lost.
- FSM states: INIT, IDLE, RESP.
- INIT:
  - Writes one byte per cycle: m[cnt] <= init value (0 unless MEM_PRELOAD_EN), then cnt++.
  - After writing byte 2**ADDR_W-1 the FSM moves to IDLE, init_done=1 and stays 1 until the next reset.
  - Sweep length is exactly 2**ADDR_W cycles; req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - On accept with req_re|req_we, the FSM goes to RESP the next cycle.
  - On accept with req_re=0 and req_we=0, the request is a no-op and the FSM stays in IDLE with no response.
- Access, performed at the accepting edge:
  - Byte k of the word (k=0 is MSB) uses address (req_addr+k) mod 2**ADDR_W, so the top address wraps to 0.
  - Write: for each k with req_be[BYTES-1-k]=1, the byte is written.
  - Read: rsp_rdata is captured at the same edge from pre-write contents. Read and write together returns the old data, then updates the array.
  - req_we with req_re=0: rsp_rdata=0, and a response is still issued as the write acknowledge.
  - STRICT_ALIGN=1 with a misaligned address: no write, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err held stable; req_ready=0.
  - On rsp_ready the FSM returns to IDLE, rsp_valid=0, rsp_err=0.
  - rsp_rdata keeps its last value after the handshake.
- Latency: accept at edge N gives rsp_valid=1 after edge N. Back-to-back throughput is one transaction per 2 cycles when rsp_ready is tied high.
- Requests are ignored while not in IDLE; the requester must hold req_valid and its payload until accepted.

Optional Feature:
- MEM_PRELOAD_EN defined: the INIT sweep writes bytes 0x00-0x09 as 2B CD 00 00 12 34 DE AD BE EF; all other bytes are 0.
- MEM_PRELOAD_EN undefined: every byte initialises to 0x00.
- Sweep length and timing are identical in both cases.

Test Plan:
- Reset low 1 cycle, then high → init_done rises after exactly 256 cycles (ADDR_W=8); req_ready stays 0 until then.
- MEM_PRELOAD_EN, read addr 0x06 → rsp_rdata=0xDEAD, rsp_err=0. Without the macro, the same read returns 0x0000.
- Write addr 0x20 data 0xA5C3 be=2'b10, then read 0x20 → 0xA500. Then write be=2'b01 data 0x1122 and read → 0xA522.
- Write addr 0xFF data 0x7788 be=11 (STRICT_ALIGN=0), then read 0xFF → 0x7788, and byte 0x00 reads back as 0x88 via a read of 0x00.
- Write 0x1234 at 0x40, then a simultaneous re+we of 0x40 with data 0xBEEF → response 0x1234; the next read returns 0xBEEF.
- STRICT_ALIGN=1: write 0x41 → rsp_err=1, memory unchanged. Hold rsp_ready=0 for 3 cycles → rsp_valid remains and req_ready stays 0. Assert reset in RESP → rsp_valid=0 the next cycle and INIT restarts.
